// File: rtl/io_uart_fifo.sv
// io_uart_fifo: memory-mapped LED register plus 8N1 UART transmitter with TX FIFO
// Ports:
//   clk_i / reset_i           system clock, asynchronous active-low reset
//   IO_memAddr_i [5:2]        one-hot register select (LEDS, UART_DAT, UART_CTRL, UART_DIV)
//   IO_memRData_o             OR of all selected registers, combinational
//   IO_memWData_i/IO_memWr_i  write data and single-cycle write strobe
//   leds_o                    LED register
//   txd_o                     registered serial output, idle high
//   irq_o                     IRQ_EN & FIFO empty & serializer idle
module io_uart_fifo #(
    parameter int NUM_LEDS   = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_RESET  = 217
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [31:0]         IO_memAddr_i,
    output logic [31:0]         IO_memRData_o,
    input  logic [31:0]         IO_memWData_i,
    input  logic                IO_memWr_i,
    output logic [NUM_LEDS-1:0] leds_o,
    output logic                txd_o,
    output logic                irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_LEDS-1:0]  r_leds;
    logic [DIV_WIDTH-1:0] r_div, r_d, w_d_nxt, r_tick, w_tick_nxt;
    logic                 r_irq_en, r_ovf, r_txd, w_txd_nxt;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wp, r_rp;
    logic [CW-1:0]        r_cnt;
    logic [7:0]           r_shift, w_shift_nxt;
    logic [2:0]           r_bit, w_bit_nxt;
    logic [3:0]           w_sel;
    logic                 w_wr_leds, w_wr_dat, w_wr_ctrl, w_wr_div;
    logic                 w_full, w_empty, w_active, w_push, w_pop, w_tick_end;
    logic [31:0]          w_ctrl;
    logic                 w_unused;

    assign w_sel     = IO_memAddr_i[5:2];
    assign w_wr_leds = IO_memWr_i & w_sel[0];
    assign w_wr_dat  = IO_memWr_i & w_sel[1];
    assign w_wr_ctrl = IO_memWr_i & w_sel[2];
    assign w_wr_div  = IO_memWr_i & w_sel[3];
    assign w_unused  = ^{IO_memAddr_i[31:6], IO_memAddr_i[1:0], IO_memWData_i};

    assign w_full     = r_cnt == CW'(FIFO_DEPTH);
    assign w_empty    = r_cnt == '0;
    assign w_active   = !w_empty || r_state != IDLE;
    // full is judged before any same-cycle pop, so a write at full is always dropped
    assign w_push     = w_wr_dat & ~w_full;
    assign w_tick_end = r_tick == r_d - DIV_WIDTH'(1);

    assign w_ctrl = {16'(r_cnt), 3'b0, r_irq_en, r_ovf, w_empty, w_full, w_active, 8'b0};
    assign IO_memRData_o = ({32{w_sel[0]}} & 32'(r_leds)) |
                           ({32{w_sel[2]}} & w_ctrl) |
                           ({32{w_sel[3]}} & 32'(r_div));

    assign leds_o = r_leds;
    assign txd_o  = r_txd;
    assign irq_o  = r_irq_en & w_empty & (r_state == IDLE);

    // A new frame is loaded from IDLE or directly at the end of STOP, so
    // queued bytes go out back to back without an idle cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = w_tick_end ? '0 : r_tick + DIV_WIDTH'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_d_nxt     = r_d;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: w_tick_nxt = '0;
            START: if (w_tick_end) begin
                w_state_nxt = DATA;
                w_bit_nxt   = '0;
                w_txd_nxt   = r_shift[0];
            end
            DATA: if (w_tick_end) begin
                w_state_nxt = (r_bit == 3'd7) ? STOP : DATA;
                w_bit_nxt   = r_bit + 3'd1;
                w_shift_nxt = r_shift >> 1;
                w_txd_nxt   = (r_bit == 3'd7) ? 1'b1 : r_shift[1];
            end
            STOP: if (w_tick_end) w_state_nxt = IDLE;
        endcase
        if ((r_state == IDLE || (r_state == STOP && w_tick_end)) && !w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
            w_shift_nxt = r_mem[r_rp];
            w_d_nxt     = (r_div == '0) ? DIV_WIDTH'(1) : r_div;
            w_tick_nxt  = '0;
            w_txd_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= IDLE;
            r_leds   <= '0;
            r_div    <= DIV_WIDTH'(DIV_RESET);
            r_d      <= DIV_WIDTH'(1);
            r_tick   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_txd    <= 1'b1;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_d      <= w_d_nxt;
            r_tick   <= w_tick_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_txd    <= w_txd_nxt;
            if (w_wr_leds) r_leds <= IO_memWData_i[NUM_LEDS-1:0];
            if (w_wr_div) r_div <= IO_memWData_i[DIV_WIDTH-1:0];
            if (w_wr_ctrl) r_irq_en <= IO_memWData_i[12];
            // a dropped write wins over a same-cycle clear
            r_ovf    <= (w_wr_dat & w_full) | (r_ovf & ~(w_wr_ctrl & IO_memWData_i[11]));
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt    <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wp] <= IO_memWData_i[7:0];
    end
endmodule
